// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer: FSM encoding and
// reference truth tables indexed by {in1,in2}.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2
   } state_e;

   localparam int unsigned VEC_W = 2;
   localparam logic [VEC_W-1:0] LAST_VEC = 2'b11;

   localparam logic [3:0] NAND_TRUTH = 4'b0111;
   localparam logic [3:0] AND_TRUTH  = 4'b1000;
   localparam logic [3:0] OR_TRUTH   = 4'b1110;
   localparam logic [3:0] XOR_TRUTH  = 4'b0110;
   localparam logic [3:0] NOR_TRUTH  = 4'b0001;

   function automatic logic expected_bit(input logic [3:0] tt, input logic [VEC_W-1:0] vec);
      return tt[vec];
   endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Loadable down-counter with a zero flag; times how long each vector settles.
module gate_seq_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec_en,
   output logic         zero_c
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec_en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_c = (count_q == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Self-test controller that sweeps all {in1,in2} vectors into a 2-input gate and
// scores its output against a latched truth table. GATE_SEQ_CAPTURE_EN adds first-fail capture.
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned NUM_PASSES    = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       truth_table,
   input  logic             dut_out,
   output logic             dut_in1,
   output logic             dut_in2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       fail_vec,
   output logic             fail_valid
);

   localparam int unsigned TMR_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [PASS_W-1:0]  pass_idx_q, pass_idx_d;
   logic [3:0]         table_q, table_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;

   logic               tmr_load;
   logic               tmr_dec;
   logic               tmr_zero_c;
   logic               accept_c;
   logic               check_err_c;

   assign accept_c    = (state_q == ST_IDLE) && start;
   assign check_err_c = (state_q == ST_CHECK) && (dut_out != expected_bit(table_q, vec_q));

   gate_seq_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TMR_W'(SETTLE_CYCLES - 1)),
      .dec_en   (tmr_dec),
      .zero_c   (tmr_zero_c)
   );

   // Next-state, counters and scoreboard.
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      pass_idx_d = pass_idx_q;
      table_d    = table_q;
      err_d      = err_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               table_d    = truth_table;
               err_d      = '0;
               pass_d     = 1'b0;
               busy_d     = 1'b1;
               vec_d      = '0;
               pass_idx_d = '0;
               tmr_load   = 1'b1;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero_c) begin
               state_d = ST_CHECK;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            if (check_err_c && (err_q != '1)) begin
               err_d = err_q + CNT_W'(1);
            end
            if ((vec_q == LAST_VEC) && (pass_idx_q == PASS_W'(NUM_PASSES - 1))) begin
               // pass reflects the error count including this final check
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               vec_d   = '0;
            end else begin
               vec_d = vec_q + VEC_W'(1);
               if (vec_q == LAST_VEC) begin
                  pass_idx_d = pass_idx_q + PASS_W'(1);
               end
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         vec_q      <= '0;
         pass_idx_q <= '0;
         table_q    <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pass_idx_q <= pass_idx_d;
         table_q    <= table_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

`ifdef GATE_SEQ_CAPTURE_EN
   logic [1:0] fail_vec_q, fail_vec_d;
   logic       fail_valid_q, fail_valid_d;

   // Only the first mismatch of a run is kept.
   always_comb begin
      fail_vec_d   = fail_vec_q;
      fail_valid_d = fail_valid_q;
      if (accept_c) begin
         fail_vec_d   = '0;
         fail_valid_d = 1'b0;
      end else if (check_err_c && !fail_valid_q) begin
         fail_vec_d   = vec_q;
         fail_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_vec_q   <= '0;
         fail_valid_q <= 1'b0;
      end else begin
         fail_vec_q   <= fail_vec_d;
         fail_valid_q <= fail_valid_d;
      end
   end

   assign fail_vec   = fail_vec_q;
   assign fail_valid = fail_valid_q;
`else
   assign fail_vec   = 2'b00;
   assign fail_valid = 1'b0;
`endif

   assign dut_in1   = vec_q[1];
   assign dut_in2   = vec_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer with a behavioural gate model and a
// result scoreboard; a second instance with a 2-bit error counter runs in lockstep.
module tb_gate_vector_sequencer;
   import gate_seq_pkg::*;

   localparam int TB_SETTLE = 4;
   localparam int TB_PASSES = 2;
   localparam int TB_PER    = TB_SETTLE + 1;
   localparam int TB_DONE   = 4 * TB_PASSES * TB_PER;

`ifdef GATE_SEQ_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   localparam int M_NAND     = 0;
   localparam int M_STUCK1   = 1;
   localparam int M_AND      = 2;
   localparam int M_INV_NAND = 3;
   localparam int M_GLITCH   = 4;
   localparam int M_XOR      = 5;

   typedef struct {
      int         err8;
      int         err2;
      logic       pass;
      logic [1:0] fvec;
      logic       fvalid;
   } exp_t;

   logic       clk, rst, start, dut_out;
   logic [3:0] truth;
   logic       dut_in1, dut_in2, busy, done, pass, fail_valid;
   logic [7:0] err_count;
   logic [1:0] fail_vec;
   logic       d2_in1, d2_in2, d2_busy, d2_done, d2_pass, d2_fail_valid;
   logic [1:0] d2_err, d2_fail_vec;

   int   gate_mode;
   int   run_cyc;
   int   n_pass, n_fail, n_total;
   exp_t sb[$];

   gate_vector_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start), .truth_table(truth), .dut_out(dut_out),
      .dut_in1(dut_in1), .dut_in2(dut_in2), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid)
   );

   gate_vector_sequencer #(.CNT_W(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .start(start), .truth_table(truth), .dut_out(dut_out),
      .dut_in1(d2_in1), .dut_in2(d2_in2), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
      .err_count(d2_err), .fail_vec(d2_fail_vec), .fail_valid(d2_fail_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic gate_fn(input int mode, input logic [1:0] v);
      case (mode)
         M_STUCK1:   return 1'b1;
         M_AND:      return v[1] & v[0];
         M_INV_NAND: return !(!(v[1] & v[0]));
         M_XOR:      return v[1] ^ v[0];
         default:    return !(v[1] & v[0]);
      endcase
   endfunction

   // Glitch mode drives the wrong value on every cycle except the sampling one.
   always_comb begin
      dut_out = gate_fn(gate_mode, {dut_in1, dut_in2});
      if ((gate_mode == M_GLITCH) && ((run_cyc % TB_PER) != TB_SETTLE)) dut_out = !dut_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_pass"}, 32'(pass), 0);
      check({tag, "_err"}, 32'(err_count), 0);
      check({tag, "_in"}, 32'({dut_in1, dut_in2}), 0);
      check({tag, "_fvec"}, 32'(fail_vec), 0);
      check({tag, "_fvalid"}, 32'(fail_valid), 0);
      check({tag, "_w2"}, 32'({d2_in1, d2_in2, d2_busy, d2_done, d2_pass, d2_err, d2_fail_vec, d2_fail_valid}), 0);
   endtask

   task automatic do_run(input string tag, input int mode_i, input logic [3:0] tt, input bit hold);
      exp_t e;
      int   errs, first;
      bit   got;
      logic [1:0] vv;
      errs  = 0;
      first = -1;
      for (int p = 0; p < TB_PASSES; p++) begin
         for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (gate_fn(mode_i, vv) !== tt[vv]) begin
               errs++;
               if (first < 0) first = v;
            end
         end
      end
      e.err8   = (errs > 255) ? 255 : errs;
      e.err2   = (errs > 3) ? 3 : errs;
      e.pass   = (errs == 0);
      e.fvalid = CAP && (errs > 0);
      e.fvec   = (CAP && (errs > 0)) ? 2'(first) : 2'b00;
      sb.push_back(e);

      gate_mode = mode_i;
      truth     = tt;
      start     = 1'b1;
      tick();
      run_cyc = 0;
      if (!hold) start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 1);
      check({tag, "_err_clr"}, 32'(err_count), 0);
      check({tag, "_pass_clr"}, 32'(pass), 0);

      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         if (((run_cyc % TB_PER) == 0) && (run_cyc < TB_DONE))
            check({tag, "_vec"}, 32'({dut_in1, dut_in2}), 32'((run_cyc / TB_PER) % 4));
         tick();
         run_cyc++;
         if (done === 1'b1) got = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(got), 1);

      e = sb.pop_front();
      check({tag, "_latency"}, 32'(run_cyc), 32'(TB_DONE));
      check({tag, "_err"}, 32'(err_count), 32'(e.err8));
      check({tag, "_err_w2"}, 32'(d2_err), 32'(e.err2));
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      check({tag, "_pass_w2"}, 32'(d2_pass), 32'(e.pass));
      check({tag, "_fvec"}, 32'(fail_vec), 32'(e.fvec));
      check({tag, "_fvalid"}, 32'(fail_valid), 32'(e.fvalid));
      check({tag, "_busy_end"}, 32'(busy), 0);
      check({tag, "_in_end"}, 32'({dut_in1, dut_in2}), 0);
      check({tag, "_done_w2"}, 32'(d2_done), 1);

      tick();
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_busy_after"}, 32'(busy), 32'(hold));
      check({tag, "_pass_hold"}, 32'(pass), hold ? 0 : 32'(e.pass));
      check({tag, "_err_hold"}, 32'(err_count), hold ? 0 : 32'(e.err8));
   endtask

   initial begin
      int dones;
      n_pass    = 0;
      n_fail    = 0;
      n_total   = 0;
      rst       = 1'b1;
      start     = 1'b0;
      truth     = 4'b0000;
      gate_mode = M_NAND;
      run_cyc   = 0;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();
      check_zero("idle");

      do_run("nand_ok", M_NAND, NAND_TRUTH, 1'b0);
      do_run("stuck1", M_STUCK1, NAND_TRUTH, 1'b0);
      do_run("and_vs_nand", M_AND, NAND_TRUTH, 1'b0);
      do_run("inv_nand_sat", M_INV_NAND, NAND_TRUTH, 1'b0);
      do_run("glitch", M_GLITCH, NAND_TRUTH, 1'b0);
      do_run("xor_ok", M_XOR, XOR_TRUTH, 1'b0);
      do_run("xor_vs_nor", M_XOR, NOR_TRUTH, 1'b0);
      do_run("and_vs_or", M_AND, OR_TRUTH, 1'b0);

      // start held through the run: the next run begins right after done
      do_run("held", M_NAND, NAND_TRUTH, 1'b1);
      repeat (9) tick();
      check("held_busy_mid", 32'(busy), 1);
      rst   = 1'b1;
      start = 1'b0;
      tick();
      check_zero("mid_reset");
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (done === 1'b1 || d2_done === 1'b1) dones++;
      end
      check("abort_no_done", 32'(dones), 0);
      check("abort_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
